pmod_axi_ram: RTL and testbench
===============================

Name: pmod_axi_ram

Overview:
AXI4 burst slave memory sitting directly downstream of the pmod bridge's 64-bit AXI master port; it terminates the AW/W/B/AR/R channels the bridge drives. It is the bring-up target for pmod-link read/write bursts and the FPGA-side scratch buffer. The block has a single-port synchronous RAM with one channel FSM that serialises read and write bursts.

Parameters:
DEPTH, 4096, number of 64-bit words; power of two.
ADDR_W, 32, AXI address width.

Ports:
S_AXI_ACLK  in  1  clock
S_AXI_ARESETN  in  1  reset, asynchronous assert, active-low
S_AXI_AWADDR  in  32  write burst byte address
S_AXI_AWLEN  in  8  beats-1
S_AXI_AWSIZE  in  3  must be 3 (8 bytes)
S_AXI_AWBURST  in  2  00 FIXED, 01 INCR, 10 WRAP (treated as INCR)
S_AXI_AWPROT  in  3  ignored
S_AXI_AWVALID/S_AXI_AWREADY  in/out  1  AW handshake
S_AXI_WDATA  in  64  write data
S_AXI_WSTRB  in  8  byte enables
S_AXI_WLAST  in  1  last write beat
S_AXI_WVALID/S_AXI_WREADY  in/out  1  W handshake
S_AXI_BVALID/S_AXI_BREADY  out/in  1  write response (always OKAY; no BRESP)
S_AXI_ARADDR, S_AXI_ARLEN, S_AXI_ARSIZE, S_AXI_ARBURST, S_AXI_ARPROT  in  32/8/3/2/3  same meaning as AW
S_AXI_ARVALID/S_AXI_ARREADY  in/out  1  AR handshake
S_AXI_RDATA  out  64  read data
S_AXI_RLAST  out  1  last read beat
S_AXI_RVALID/S_AXI_RREADY  out/in  1  R handshake
protocol_err  out  1  sticky: WLAST mismatch or size != 3

Behaviour:
- Reset (async, ARESETN low): all READY/VALID outputs 0, RLAST 0, RDATA 0, protocol_err 0, FSM in IDLE, prio = write. RAM contents are not reset. Reset mid-burst abandons the burst with no response.
- Word index = addr[log2(DEPTH)+2:3]. It increments by 1 per beat for INCR/WRAP, holds for FIXED, and wraps modulo DEPTH.
- FSM states are IDLE, WR_DATA, WR_RESP, RD_BURST.
- IDLE: AWREADY = AWVALID and grant_w; ARREADY = ARVALID and grant_r.
- If only one of AWVALID/ARVALID is high, that channel is granted.
- If both are high, the channel named by prio is granted, and prio toggles after each grant.
- Only one handshake occurs per cycle.
- AW handshake at cycle N: latch address/len/burst, beat count = 0, go to WR_DATA. WREADY = 1 from N+1.
- WR_DATA: each W handshake writes WDATA byte lanes where WSTRB=1, then increments the beat count.
  - On the beat where count == AWLEN, go to WR_RESP; BVALID rises the next cycle.
  - If WLAST != (count == AWLEN) on any beat, protocol_err is set; the beat count (AWLEN) governs termination.
- WR_RESP: BVALID held until BREADY, then go to IDLE. AWREADY may assert in the cycle after the B handshake.
- AR handshake at cycle N: go to RD_BURST. RAM read issue starts N+1; first RVALID at N+2.
- RD_BURST: 2-entry output FIFO (RDATA/RLAST).
  - A RAM read is issued when the FIFO has free space counting reads in flight.
  - Throughput is 1 beat/cycle with RREADY held high.
  - With RREADY low, the FIFO holds; RVALID/RDATA/RLAST stay stable until accepted.
  - RLAST = 1 on beat ARLEN. The R handshake on RLAST returns the FSM to IDLE.
- AWSIZE/ARSIZE != 3 sets protocol_err; the burst is executed as size 3.
- ARLEN/AWLEN = 0 gives a single-beat burst; the maximum is 256 beats.
- protocol_err clears only on reset.

Decomposition:
- Package pmod_axi_pkg: burst encodings (FIXED/INCR/WRAP), SIZE_64 = 3, FSM state enum. The bridge AXI master shares this package.
- Sub-module pmod_ram_sp: single-port RAM with 8 byte-write enables and 1-cycle registered read, so the FPGA flow infers BRAM.
- The 2-entry R FIFO stays inline.

Test Plan:
- Write INCR len=3 at 0x100 with data 0x11..,0x22..,0x33..,0x44.., then read len=3 at 0x100. Required response: BVALID once, R beats return the same four words, RLAST on the 4th, first RVALID 2 cycles after the AR handshake.
- Write 0xFFFF_FFFF_FFFF_FFFF at 0x0, then write 0x0 with WSTRB=0x0F. Required response: readback is 0xFFFF_FFFF_0000_0000.
- Read len=7 with RREADY toggling 1/0 every cycle. Required response: 8 beats in order, no loss or duplication, RDATA stable while stalled.
- AWVALID and ARVALID asserted in the same cycle from reset. Required response: write granted first; the next simultaneous pair grants read.
- Write len=3 with WLAST on beat 2. Required response: protocol_err = 1, burst ends after beat 3, BVALID issued. Then FIXED write len=1 at DEPTH*8-8: both beats hit the last word, and the INCR read wraps to word 0.
- Deassert ARESETN mid read burst. Required response: RVALID/ARREADY go 0 immediately, FSM in IDLE; a new write-then-read completes normally.

Source files
------------

// File: rtl/pmod_axi_pkg.sv
// Shared AXI encodings and channel FSM states for the pmod bridge master and the
// AXI RAM slave.
package pmod_axi_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [2:0] SIZE_64 = 3'd3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WR_DATA,
    ST_WR_RESP,
    ST_RD_BURST
  } axi_state_e;

  typedef enum logic {
    PRIO_WR,
    PRIO_RD
  } prio_e;

endpackage

// File: rtl/pmod_ram_sp.sv
// Single-port 64-bit RAM with per-byte write enables and a registered read port.
// The output holds its value whenever no read is issued.
module pmod_ram_sp #(
  parameter int DEPTH = 4096,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          en_i,
  input  logic          we_i,
  input  logic [7:0]    be_i,
  input  logic [AW-1:0] addr_i,
  input  logic [63:0]   wdata_i,
  output logic [63:0]   rdata_o
);

  logic [63:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (en_i) begin
      if (we_i) begin
        for (int b = 0; b < 8; b++) begin
          if (be_i[b]) begin
            mem_q[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
          end
        end
      end else begin
        rdata_o <= mem_q[addr_i];
      end
    end
  end

endmodule

// File: rtl/pmod_axi_ram.sv
// AXI4 burst slave memory behind the pmod bridge. One channel FSM serialises
// write and read bursts onto a single-port RAM; reads stream through a 2-entry FIFO.
module pmod_axi_ram
  import pmod_axi_pkg::*;
#(
  parameter int DEPTH  = 4096,
  parameter int ADDR_W = 32
) (
  input  logic              S_AXI_ACLK,
  input  logic              S_AXI_ARESETN,
  input  logic [ADDR_W-1:0] S_AXI_AWADDR,
  input  logic [7:0]        S_AXI_AWLEN,
  input  logic [2:0]        S_AXI_AWSIZE,
  input  logic [1:0]        S_AXI_AWBURST,
  input  logic [2:0]        S_AXI_AWPROT,
  input  logic              S_AXI_AWVALID,
  output logic              S_AXI_AWREADY,
  input  logic [63:0]       S_AXI_WDATA,
  input  logic [7:0]        S_AXI_WSTRB,
  input  logic              S_AXI_WLAST,
  input  logic              S_AXI_WVALID,
  output logic              S_AXI_WREADY,
  output logic              S_AXI_BVALID,
  input  logic              S_AXI_BREADY,
  input  logic [ADDR_W-1:0] S_AXI_ARADDR,
  input  logic [7:0]        S_AXI_ARLEN,
  input  logic [2:0]        S_AXI_ARSIZE,
  input  logic [1:0]        S_AXI_ARBURST,
  input  logic [2:0]        S_AXI_ARPROT,
  input  logic              S_AXI_ARVALID,
  output logic              S_AXI_ARREADY,
  output logic [63:0]       S_AXI_RDATA,
  output logic              S_AXI_RLAST,
  output logic              S_AXI_RVALID,
  input  logic              S_AXI_RREADY,
  output logic              protocol_err
);

  localparam int IDX_W = $clog2(DEPTH);
  typedef logic [IDX_W-1:0] idx_t;

  axi_state_e state_q, state_d;
  prio_e      prio_q, prio_d;
  logic       live_q;
  idx_t       idx_q, idx_d;
  logic [7:0] len_q, len_d, cnt_q, cnt_d;
  logic       fixed_q, fixed_d;
  logic       rd_done_q, rd_done_d;
  logic       err_q, err_d;

  logic       infl_q, infl_d, infl_last_q, infl_last_d;
  logic [1:0] fcnt_q, fcnt_d;
  logic       wptr_q, wptr_d, rptr_q, rptr_d;
  logic [63:0] fdata_q [2];
  logic [1:0]  flast_q;

  logic        grant_w, grant_r, aw_ready, ar_ready;
  logic        w_hs, issue, r_valid, r_last, r_hs, push, pop_fifo;
  logic [1:0]  occ;
  logic [63:0] r_data, ram_rdata;
  logic        unused_ok;

  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR, S_AXI_ARADDR,
                       S_AXI_AWBURST, S_AXI_ARBURST};

  assign grant_w = S_AXI_AWVALID && (!S_AXI_ARVALID || prio_q == PRIO_WR);
  assign grant_r = S_AXI_ARVALID && !grant_w;
  assign w_hs    = (state_q == ST_WR_DATA) && S_AXI_WVALID;

  // Output side: FIFO head when occupied, otherwise the RAM word landing this cycle.
  assign r_valid  = (fcnt_q != 2'd0) || infl_q;
  assign r_data   = (fcnt_q != 2'd0) ? fdata_q[rptr_q] : (infl_q ? ram_rdata : 64'd0);
  assign r_last   = (fcnt_q != 2'd0) ? flast_q[rptr_q] : (infl_q && infl_last_q);
  assign r_hs     = r_valid && S_AXI_RREADY;
  assign pop_fifo = (fcnt_q != 2'd0) && S_AXI_RREADY;
  assign push     = infl_q && !((fcnt_q == 2'd0) && S_AXI_RREADY);
  assign occ      = fcnt_q + {1'b0, infl_q} - {1'b0, r_hs};
  assign issue    = (state_q == ST_RD_BURST) && !rd_done_q && (occ < 2'd2);

  always_comb begin
    state_d   = state_q;
    prio_d    = prio_q;
    idx_d     = idx_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    fixed_d   = fixed_q;
    rd_done_d = rd_done_q;
    err_d     = err_q;
    aw_ready  = 1'b0;
    ar_ready  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (live_q) begin
          aw_ready = grant_w;
          ar_ready = grant_r;
          if (grant_w || grant_r) begin
            prio_d = (prio_q == PRIO_WR) ? PRIO_RD : PRIO_WR;
            cnt_d  = 8'd0;
          end
          if (grant_w) begin
            idx_d   = S_AXI_AWADDR[IDX_W+2:3];
            len_d   = S_AXI_AWLEN;
            fixed_d = (S_AXI_AWBURST == BURST_FIXED);
            if (S_AXI_AWSIZE != SIZE_64) err_d = 1'b1;
            state_d = ST_WR_DATA;
          end else if (grant_r) begin
            idx_d     = S_AXI_ARADDR[IDX_W+2:3];
            len_d     = S_AXI_ARLEN;
            fixed_d   = (S_AXI_ARBURST == BURST_FIXED);
            rd_done_d = 1'b0;
            if (S_AXI_ARSIZE != SIZE_64) err_d = 1'b1;
            state_d = ST_RD_BURST;
          end
        end
      end
      ST_WR_DATA: begin
        if (w_hs) begin
          cnt_d = cnt_q + 8'd1;
          if (!fixed_q) idx_d = idx_q + idx_t'(1);
          if (S_AXI_WLAST != (cnt_q == len_q)) err_d = 1'b1;
          if (cnt_q == len_q) state_d = ST_WR_RESP;
        end
      end
      ST_WR_RESP: begin
        if (S_AXI_BREADY) state_d = ST_IDLE;
      end
      ST_RD_BURST: begin
        if (issue) begin
          cnt_d = cnt_q + 8'd1;
          if (!fixed_q) idx_d = idx_q + idx_t'(1);
          if (cnt_q == len_q) rd_done_d = 1'b1;
        end
        if (r_hs && r_last) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    infl_d      = issue;
    infl_last_d = issue && (cnt_q == len_q);
    fcnt_d      = fcnt_q + {1'b0, push} - {1'b0, pop_fifo};
    wptr_d      = wptr_q ^ push;
    rptr_d      = rptr_q ^ pop_fifo;
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      state_q     <= ST_IDLE;
      prio_q      <= PRIO_WR;
      live_q      <= 1'b0;
      idx_q       <= '0;
      len_q       <= 8'd0;
      cnt_q       <= 8'd0;
      fixed_q     <= 1'b0;
      rd_done_q   <= 1'b0;
      err_q       <= 1'b0;
      infl_q      <= 1'b0;
      infl_last_q <= 1'b0;
      fcnt_q      <= 2'd0;
      wptr_q      <= 1'b0;
      rptr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      prio_q      <= prio_d;
      live_q      <= 1'b1;
      idx_q       <= idx_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      fixed_q     <= fixed_d;
      rd_done_q   <= rd_done_d;
      err_q       <= err_d;
      infl_q      <= infl_d;
      infl_last_q <= infl_last_d;
      fcnt_q      <= fcnt_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
    end
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (push) begin
      fdata_q[wptr_q] <= ram_rdata;
      flast_q[wptr_q] <= infl_last_q;
    end
  end

  pmod_ram_sp #(.DEPTH(DEPTH)) u_ram (
    .clk_i   (S_AXI_ACLK),
    .en_i    (w_hs || issue),
    .we_i    (w_hs),
    .be_i    (S_AXI_WSTRB),
    .addr_i  (idx_q),
    .wdata_i (S_AXI_WDATA),
    .rdata_o (ram_rdata)
  );

  assign S_AXI_AWREADY = aw_ready;
  assign S_AXI_ARREADY = ar_ready;
  assign S_AXI_WREADY  = (state_q == ST_WR_DATA);
  assign S_AXI_BVALID  = (state_q == ST_WR_RESP);
  assign S_AXI_RVALID  = r_valid;
  assign S_AXI_RDATA   = r_data;
  assign S_AXI_RLAST   = r_last;
  assign protocol_err  = err_q;

endmodule

// File: tb/tb_pmod_axi_ram.sv
// Directed bench for pmod_axi_ram: expected R beats and B responses are queued when
// stimulus is issued and consumed by a monitor that watches the R and B channels.
module tb_pmod_axi_ram;
  import pmod_axi_pkg::*;

  localparam int DEPTH = 4096;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] awaddr = '0, araddr = '0;
  logic [7:0]  awlen = '0, arlen = '0;
  logic [2:0]  awsize = 3'd3, arsize = 3'd3, awprot = '0, arprot = '0;
  logic [1:0]  awburst = 2'b01, arburst = 2'b01;
  logic        awvalid = 1'b0, arvalid = 1'b0;
  logic        awready, arready, wready, bvalid, rvalid, rlast, protocol_err;
  logic [63:0] wdata = '0, rdata;
  logic [7:0]  wstrb = '0;
  logic        wlast = 1'b0, wvalid = 1'b0;
  logic        bready = 1'b1, rready = 1'b1;

  int checks = 0, errors = 0, cyc = 0, exp_b = 0, r_cnt = 0;
  logic [64:0] exp_rq[$];
  logic [63:0] wq[$];
  logic [7:0]  sq[$];
  logic        lq[$];
  logic        rr_toggle = 1'b0;
  logic        stall_q = 1'b0;
  logic [64:0] held = '0, mon_e;

  pmod_axi_ram #(.DEPTH(DEPTH), .ADDR_W(32)) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWLEN(awlen), .S_AXI_AWSIZE(awsize),
    .S_AXI_AWBURST(awburst), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid),
    .S_AXI_AWREADY(awready), .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb),
    .S_AXI_WLAST(wlast), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARLEN(arlen), .S_AXI_ARSIZE(arsize),
    .S_AXI_ARBURST(arburst), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid),
    .S_AXI_ARREADY(arready), .S_AXI_RDATA(rdata), .S_AXI_RLAST(rlast),
    .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready), .protocol_err(protocol_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(posedge clk) begin
    #1;
    rready = rr_toggle ? ~rready : 1'b1;
  end

  task automatic chk(input string nm, input logic [64:0] act, input logic [64:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%b required=%b", nm, act, req);
    end
  endtask

  // Monitor: R beats against the expectation queue, stall stability, B responses.
  always @(negedge clk) begin
    if (!rst_n) begin
      stall_q = 1'b0;
    end else begin
      if (stall_q) begin
        chk1("r_stall_valid", rvalid, 1'b1);
        chk("r_stall_data", {rlast, rdata}, held);
      end
      if (rvalid && rready) begin
        r_cnt++;
        if (exp_rq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL r_extra actual=%h required=no beat", rdata);
        end else begin
          mon_e = exp_rq.pop_front();
          chk("r_beat", {rlast, rdata}, mon_e);
        end
      end
      stall_q = rvalid && !rready;
      held    = {rlast, rdata};
      if (bvalid && bready) begin
        chk1("b_expected", exp_b > 0, 1'b1);
        if (exp_b > 0) exp_b--;
      end
    end
  end

  task automatic push_w(input logic [63:0] d, input logic [7:0] s, input logic l);
    wq.push_back(d);
    sq.push_back(s);
    lq.push_back(l);
  endtask

  task automatic aw_send(input logic [31:0] a, input logic [7:0] len, input logic [1:0] bu,
                         input logic [2:0] sz, output int hc);
    bit ok = 0;
    awaddr = a; awlen = len; awburst = bu; awsize = sz; awvalid = 1'b1;
    hc = -1;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (awready) begin ok = 1; hc = cyc; break; end
    end
    chk1("aw_handshake", ok, 1'b1);
    @(posedge clk); #1;
    awvalid = 1'b0;
  endtask

  task automatic ar_send(input logic [31:0] a, input logic [7:0] len, input logic [1:0] bu,
                         input logic [2:0] sz, output int hc);
    bit ok = 0;
    araddr = a; arlen = len; arburst = bu; arsize = sz; arvalid = 1'b1;
    hc = -1;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (arready) begin ok = 1; hc = cyc; break; end
    end
    chk1("ar_handshake", ok, 1'b1);
    @(posedge clk); #1;
    arvalid = 1'b0;
  endtask

  task automatic w_send(input int n);
    for (int i = 0; i < n; i++) begin
      bit ok = 0;
      wdata = wq.pop_front(); wstrb = sq.pop_front(); wlast = lq.pop_front(); wvalid = 1'b1;
      for (int k = 0; k < 300; k++) begin
        @(negedge clk);
        if (wready) begin ok = 1; break; end
      end
      if (!ok) begin
        checks++; errors++;
        $display("FAIL w_handshake actual=timeout required=wready beat %0d", i);
      end
      @(posedge clk); #1;
    end
    wvalid = 1'b0;
    wlast  = 1'b0;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [7:0] len, input logic [1:0] bu,
                          input logic [2:0] sz);
    int hc;
    exp_b++;
    aw_send(a, len, bu, sz, hc);
    w_send(int'(len) + 1);
  endtask

  task automatic wait_drain(input string nm);
    int k = 0;
    while ((exp_rq.size() != 0 || exp_b != 0) && k < 2000) begin
      @(negedge clk);
      k++;
    end
    chk(nm, 65'(exp_rq.size() + exp_b), 65'd0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    int hc, aw1, aw2, ar1, base, k;

    // Reset state: readies stay low even with both address channels requesting.
    awvalid = 1'b1; arvalid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ctrl", 65'({awready, arready, wready, bvalid, rvalid, rlast, protocol_err}), 65'd0);
    chk("rst_rdata", 65'(rdata), 65'd0);
    awvalid = 1'b0; arvalid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk); #1;

    // T1: 4-beat INCR write, readback with first-RVALID latency.
    push_w(64'h1111_1111_1111_1111, 8'hFF, 1'b0);
    push_w(64'h2222_2222_2222_2222, 8'hFF, 1'b0);
    push_w(64'h3333_3333_3333_3333, 8'hFF, 1'b0);
    push_w(64'h4444_4444_4444_4444, 8'hFF, 1'b1);
    do_write(32'h100, 8'd3, BURST_INCR, SIZE_64);
    wait_drain("t1_write_done");
    exp_rq.push_back({1'b0, 64'h1111_1111_1111_1111});
    exp_rq.push_back({1'b0, 64'h2222_2222_2222_2222});
    exp_rq.push_back({1'b0, 64'h3333_3333_3333_3333});
    exp_rq.push_back({1'b1, 64'h4444_4444_4444_4444});
    ar_send(32'h100, 8'd3, BURST_INCR, SIZE_64, hc);
    @(negedge clk); chk1("t1_rvalid_n1", rvalid, 1'b0);
    @(negedge clk); chk1("t1_rvalid_n2", rvalid, 1'b1);
    wait_drain("t1_read_done");

    // T2: byte strobes merge into an existing word.
    push_w(64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 1'b1);
    do_write(32'h0, 8'd0, BURST_INCR, SIZE_64);
    push_w(64'h0, 8'h0F, 1'b1);
    do_write(32'h0, 8'd0, BURST_INCR, SIZE_64);
    exp_rq.push_back({1'b1, 64'hFFFF_FFFF_0000_0000});
    ar_send(32'h0, 8'd0, BURST_INCR, SIZE_64, hc);
    wait_drain("t2_done");

    // T3: 8-beat read with RREADY toggling every cycle.
    for (int i = 0; i < 8; i++) push_w(64'hC0DE_0000_0000_0000 | 64'(i), 8'hFF, i == 7);
    do_write(32'h200, 8'd7, BURST_INCR, SIZE_64);
    wait_drain("t3_write_done");
    for (int i = 0; i < 8; i++) exp_rq.push_back({i == 7, 64'hC0DE_0000_0000_0000 | 64'(i)});
    rr_toggle = 1'b1;
    ar_send(32'h200, 8'd7, BURST_INCR, SIZE_64, hc);
    wait_drain("t3_read_done");
    rr_toggle = 1'b0;
    repeat (2) @(posedge clk); #1;

    // T4: simultaneous AW/AR from reset grants write, the next contested pair grants read.
    rst_n = 1'b0;
    repeat (2) @(posedge clk); #1;
    rst_n = 1'b1;
    push_w(64'h5555_5555_5555_5555, 8'hFF, 1'b1);
    push_w(64'h6666_6666_6666_6666, 8'hFF, 1'b1);
    exp_b += 2;
    exp_rq.push_back({1'b1, 64'h1111_1111_1111_1111});
    fork
      begin
        aw_send(32'h300, 8'd0, BURST_INCR, SIZE_64, aw1);
        aw_send(32'h308, 8'd0, BURST_INCR, SIZE_64, aw2);
      end
      ar_send(32'h100, 8'd0, BURST_INCR, SIZE_64, ar1);
      w_send(2);
    join
    chk1("t4_write_first", aw1 < ar1, 1'b1);
    chk1("t4_read_second", ar1 < aw2, 1'b1);
    wait_drain("t4_done");

    // T5: early WLAST flags an error but the length still governs; FIXED at top word.
    chk1("t5_err_clear", protocol_err, 1'b0);
    push_w(64'hA1A1_A1A1_A1A1_A1A1, 8'hFF, 1'b0);
    push_w(64'hA2A2_A2A2_A2A2_A2A2, 8'hFF, 1'b0);
    push_w(64'hA3A3_A3A3_A3A3_A3A3, 8'hFF, 1'b1);
    push_w(64'hA4A4_A4A4_A4A4_A4A4, 8'hFF, 1'b0);
    do_write(32'h400, 8'd3, BURST_INCR, SIZE_64);
    wait_drain("t5_write_done");
    chk1("t5_err_set", protocol_err, 1'b1);
    exp_rq.push_back({1'b0, 64'hA3A3_A3A3_A3A3_A3A3});
    exp_rq.push_back({1'b1, 64'hA4A4_A4A4_A4A4_A4A4});
    ar_send(32'h410, 8'd1, BURST_INCR, SIZE_64, hc);
    wait_drain("t5_tail_read");
    push_w(64'hAAAA_AAAA_AAAA_AAAA, 8'hFF, 1'b0);
    push_w(64'hBBBB_BBBB_BBBB_BBBB, 8'hFF, 1'b1);
    do_write(32'(DEPTH * 8 - 8), 8'd1, BURST_FIXED, SIZE_64);
    wait_drain("t5_fixed_done");
    exp_rq.push_back({1'b0, 64'hBBBB_BBBB_BBBB_BBBB});
    exp_rq.push_back({1'b1, 64'hFFFF_FFFF_0000_0000});
    ar_send(32'(DEPTH * 8 - 8), 8'd1, BURST_INCR, SIZE_64, hc);
    wait_drain("t5_wrap_read");
    chk1("t5_err_sticky", protocol_err, 1'b1);

    // T6: reset in the middle of a read burst, then a clean write/read.
    for (int i = 0; i < 8; i++) exp_rq.push_back({i == 7, 64'hC0DE_0000_0000_0000 | 64'(i)});
    base = r_cnt;
    ar_send(32'h200, 8'd7, BURST_INCR, SIZE_64, hc);
    k = 0;
    while (r_cnt < base + 3 && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk1("t6_beats_seen", r_cnt >= base + 3, 1'b1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    arvalid = 1'b1;
    #1;
    chk1("t6_rst_rvalid", rvalid, 1'b0);
    chk1("t6_rst_arready", arready, 1'b0);
    chk1("t6_rst_err", protocol_err, 1'b0);
    exp_rq.delete();
    arvalid = 1'b0;
    repeat (2) @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    push_w(64'h0123_4567_89AB_CDEF, 8'hFF, 1'b0);
    push_w(64'hFEDC_BA98_7654_3210, 8'hFF, 1'b1);
    do_write(32'h500, 8'd1, BURST_INCR, SIZE_64);
    wait_drain("t6_write_done");
    chk1("t6_err_after_write", protocol_err, 1'b0);
    exp_rq.push_back({1'b0, 64'h0123_4567_89AB_CDEF});
    exp_rq.push_back({1'b1, 64'hFEDC_BA98_7654_3210});
    ar_send(32'h500, 8'd1, BURST_INCR, 3'd2, hc);
    wait_drain("t6_read_done");
    chk1("t6_size_err", protocol_err, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
